// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : dmem_arbiter_pkg
//  Purpose : Shared constants and the response-owner type for the data-memory
//            arbiter.
//  Contents: SUBCORE_NUM        - default number of subcore requesters
//            DATA_MEM_ADDR_W    - default data-memory word-address width
//            arb_owner_t        - response tag owner (MAIN, SUB0, SUB0+1, ...)
//            sub_owner()        - owner code for subcore index i
//  Revision: 1.0 - initial release
// ============================================================================
package dmem_arbiter_pkg;

    localparam int SUBCORE_NUM     = 4;
    localparam int DATA_MEM_ADDR_W = 17;

    // Owner codes are MAIN=0 and subcore i = SUB0+i; eight bits cover any
    // realistic subcore count.
    localparam int c_OWNER_W = 8;

    typedef enum logic [c_OWNER_W-1:0] {
        OWNER_MAIN = 8'd0,
        OWNER_SUB0 = 8'd1
    } arb_owner_t;

    function automatic arb_owner_t sub_owner(input int unsigned idx);
        return arb_owner_t'(c_OWNER_W'(idx + 1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module  : dmem_arbiter_rr_pick
//  Purpose : Combinational round-robin selector. Scans the request vector
//            starting at the pointer position and picks the first requester.
//  Ports   : i_req  [N]      request vector
//            i_ptr  [PTR_W]  index with highest priority this cycle (< N)
//            o_gnt  [N]      one-hot grant (zero when nothing requests)
//            o_idx  [PTR_W]  index of the granted requester
//            o_any           at least one request present
//  Revision: 1.0 - initial release
// ============================================================================
module dmem_arbiter_rr_pick #(
    parameter int N     = 4,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N-1:0]     o_gnt,
    output logic [PTR_W-1:0] o_idx,
    output logic             o_any
);

    // One spare bit so ptr + offset never overflows before the wrap.
    logic [PTR_W:0]   w_sum;
    logic [PTR_W-1:0] w_cand;

    always_comb begin
        o_gnt  = '0;
        o_idx  = '0;
        o_any  = 1'b0;
        w_sum  = '0;
        w_cand = '0;
        for (int k = 0; k < N; k++) begin
            w_sum = {1'b0, i_ptr} + (PTR_W+1)'(k);
            if (w_sum >= (PTR_W+1)'(N)) begin
                w_sum = w_sum - (PTR_W+1)'(N);
            end
            w_cand = w_sum[PTR_W-1:0];
            if (!o_any && i_req[w_cand]) begin
                o_gnt[w_cand] = 1'b1;
                o_idx         = w_cand;
                o_any         = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : dmem_arbiter
//  Purpose : Shares the single data-memory port between the main core and
//            SUBCORE_NUM subcores. One grant per cycle, main core first, then
//            subcores in round-robin order. Response is tagged and returned
//            one cycle after the grant.
//  Config  : `define DMEM_ARB_STARVE_GUARD_EN enables the starvation guard:
//            after STARVE_LIMIT consecutive main wins against a waiting
//            subcore, the round-robin subcore wins for one cycle.
//  Ports   : clk, rstn (synchronous, active-low)
//            main_req_valid/we/addr/din   main-core request
//            main_stall, main_resp_valid   main-core handshake / response
//            sub_req_valid/we/addr/din     per-subcore request
//            sub_req_ready, sub_resp_valid per-subcore grant / response
//            resp_dout                     read data for the active response
//            mem_en/we/addr/din, mem_dout  shared synchronous memory port
//  Revision: 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int SUBCORE_NUM  = dmem_arbiter_pkg::SUBCORE_NUM,
    parameter int ADDR_W       = dmem_arbiter_pkg::DATA_MEM_ADDR_W,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                                clk,
    input  logic                                rstn,

    input  logic                                main_req_valid,
    input  logic                                main_req_we,
    input  logic [ADDR_W-1:0]                   main_req_addr,
    input  logic [31:0]                         main_req_din,
    output logic                                main_stall,
    output logic                                main_resp_valid,

    input  logic [SUBCORE_NUM-1:0]              sub_req_valid,
    input  logic [SUBCORE_NUM-1:0]              sub_req_we,
    input  logic [SUBCORE_NUM-1:0][ADDR_W-1:0]  sub_req_addr,
    input  logic [SUBCORE_NUM-1:0][31:0]        sub_req_din,
    output logic [SUBCORE_NUM-1:0]              sub_req_ready,
    output logic [SUBCORE_NUM-1:0]              sub_resp_valid,

    output logic [31:0]                         resp_dout,

    output logic                                mem_en,
    output logic                                mem_we,
    output logic [ADDR_W-1:0]                   mem_addr,
    output logic [31:0]                         mem_din,
    input  logic [31:0]                         mem_dout
);

    localparam int c_PTR_W = (SUBCORE_NUM > 1) ? $clog2(SUBCORE_NUM) : 1;

    logic [c_PTR_W-1:0]     r_rr_ptr;
    logic                   r_tag_valid;
    arb_owner_t             r_tag_owner;

    logic [SUBCORE_NUM-1:0] w_rr_gnt;
    logic [c_PTR_W-1:0]     w_rr_idx;
    logic                   w_rr_any;
    logic                   w_force_sub;
    logic                   w_main_gnt;
    logic                   w_sub_gnt;

    // ------------------------------------------------------------------
    // Round-robin candidate among the subcores
    // ------------------------------------------------------------------
    dmem_arbiter_rr_pick #(
        .N     (SUBCORE_NUM),
        .PTR_W (c_PTR_W)
    ) u_rr_pick (
        .i_req (sub_req_valid),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_rr_gnt),
        .o_idx (w_rr_idx),
        .o_any (w_rr_any)
    );

    // ------------------------------------------------------------------
    // Starvation guard
    // ------------------------------------------------------------------
`ifdef DMEM_ARB_STARVE_GUARD_EN
    localparam int c_CNT_W = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT + 1) : 1;

    logic [c_CNT_W-1:0] r_starve_cnt;

    assign w_force_sub = w_rr_any && (r_starve_cnt == c_CNT_W'(STARVE_LIMIT));

    // Counts main wins against a waiting subcore; saturates at the limit,
    // where the forced subcore grant clears it.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_starve_cnt <= '0;
        end else if (w_sub_gnt || !w_rr_any) begin
            r_starve_cnt <= '0;
        end else if (w_main_gnt && (r_starve_cnt != c_CNT_W'(STARVE_LIMIT))) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end
`else
    // Strict main priority; STARVE_LIMIT only matters with the guard, and a
    // sane (non-negative) limit makes this constant zero.
    assign w_force_sub = (STARVE_LIMIT < 0);
`endif

    // ------------------------------------------------------------------
    // Grant decision (suppressed entirely while in reset)
    // ------------------------------------------------------------------
    assign w_main_gnt    = rstn && main_req_valid && !w_force_sub;
    assign w_sub_gnt     = rstn && w_rr_any && !w_main_gnt;
    assign sub_req_ready = w_sub_gnt ? w_rr_gnt : '0;
    assign main_stall    = main_req_valid && !w_main_gnt;

    // ------------------------------------------------------------------
    // Memory port mux; idle port is driven to all zeros
    // ------------------------------------------------------------------
    always_comb begin
        mem_en   = 1'b0;
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_din  = '0;
        if (w_main_gnt) begin
            mem_en   = 1'b1;
            mem_we   = main_req_we;
            mem_addr = main_req_addr;
            mem_din  = main_req_din;
        end else if (w_sub_gnt) begin
            mem_en   = 1'b1;
            mem_we   = sub_req_we[w_rr_idx];
            mem_addr = sub_req_addr[w_rr_idx];
            mem_din  = sub_req_din[w_rr_idx];
        end
    end

    // ------------------------------------------------------------------
    // Round-robin pointer: advances past the subcore just served
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_rr_ptr <= '0;
        end else if (w_sub_gnt) begin
            if (w_rr_idx == c_PTR_W'(SUBCORE_NUM - 1)) begin
                r_rr_ptr <= '0;
            end else begin
                r_rr_ptr <= w_rr_idx + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Response tag: remembers who owns the access issued this cycle
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_tag_valid <= 1'b0;
            r_tag_owner <= OWNER_MAIN;
        end else begin
            r_tag_valid <= w_main_gnt || w_sub_gnt;
            r_tag_owner <= w_main_gnt ? OWNER_MAIN : sub_owner(int'(w_rr_idx));
        end
    end

    // Responses are gated by rstn so an access in flight when reset is
    // asserted never reports completion.
    assign main_resp_valid = rstn && r_tag_valid && (r_tag_owner == OWNER_MAIN);

    generate
        for (genvar i = 0; i < SUBCORE_NUM; i++) begin : g_sub_resp
            assign sub_resp_valid[i] = rstn && r_tag_valid && (r_tag_owner == sub_owner(i));
        end
    endgenerate

    // Synchronous-read memory already lines up with the tag register.
    assign resp_dout = mem_dout;

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single data-memory port between the main core and the `SUBCORE_NUM` subcores. Each cycle it grants one requester, drives the memory port, and returns the read data one cycle later. The main core has priority, and subcores are served round-robin. An optional starvation guard forces a subcore grant after a bounded wait. The block sits between the main core memory stage, the subcore load/store units and the shared `data_mem` array.

## Interface
- `SUBCORE_NUM`, 4: number of subcore requesters (≥1).
- `ADDR_W`, 17: word-address width.
- `STARVE_LIMIT`, 8: consecutive main-core wins tolerated while any subcore waits (guard only).
- `clk` in 1: clock.
- `rstn` in 1: reset, synchronous, active-low.
- `main_req_valid` in 1: main-core request.
- `main_req_we` in 1: main-core write.
- `main_req_addr` in `ADDR_W`: main-core word address.
- `main_req_din` in 32: main-core write data.
- `main_stall` out 1: main request present but not granted this cycle.
- `main_resp_valid` out 1: main response/ack.
- `sub_req_valid` in `[SUBCORE_NUM]`: subcore request.
- `sub_req_we` in `[SUBCORE_NUM]`: subcore write.
- `sub_req_addr` in `[SUBCORE_NUM][ADDR_W]`: subcore word address.
- `sub_req_din` in `[SUBCORE_NUM][32]`: subcore write data.
- `sub_req_ready` out `[SUBCORE_NUM]`: grant (one-hot or zero).
- `sub_resp_valid` out `[SUBCORE_NUM]`: subcore response/ack.
- `resp_dout` out 32: read data for whichever `*_resp_valid` is high.
- `mem_en`, `mem_we` out 1: memory port enable and write.
- `mem_addr` out `ADDR_W`: memory port address.
- `mem_din` out 32: memory port write data.
- `mem_dout` in 32: synchronous-read data, valid one cycle after `mem_en`.

## Operation
- Grant is combinational from the current requests. At most one of main, sub[0..N-1] is granted per cycle.
- Default priority: main first, then subcores in round-robin order starting at `rr_ptr`.
- `rr_ptr` (`$clog2(SUBCORE_NUM)` bits, reset 0) moves to (granted index + 1) mod `SUBCORE_NUM` only on a subcore grant, wrapping N-1 to 0.
- The granted request drives `mem_en`=1 and its `we`/`addr`/`din` onto the memory port. With no grant, `mem_en`=0, `mem_we`=0, and the other port fields are 0.
- `main_stall` = `main_req_valid` & ~main grant. The main core holds its request while stalled.
- Subcore handshake: the transfer happens when `sub_req_valid[i]` & `sub_req_ready[i]`. The requester must hold valid and payload stable until ready. Ready never depends on a later valid.
- Response tag register (owner + valid, reset invalid) records the grant. The next cycle, the owner's `*_resp_valid` pulses for exactly one cycle, for reads and writes alike.
- `resp_dout` = `mem_dout` pass-through. Its value is defined only on a read response; for a write it is don't-care.
- Back-to-back grants are allowed every cycle. The response for the grant in cycle T appears in cycle T+1, concurrent with the grant for T+1.
- Read and write to the same address in consecutive cycles: memory order equals grant order.

## Timing
- Cycle T: request sampled, grant, memory port driven. T+1: response valid.
- Latency is 1 cycle; throughput is 1 access/cycle.
- Reset values: `rr_ptr`=0, tag invalid, starvation counter 0. All `*_resp_valid`=0 in the cycle after reset is applied.
- Reset mid-operation: an in-flight response is dropped with no `resp_valid`. Combinational outputs follow the inputs but grants are suppressed while `rstn`=0 (`mem_en`=0, all ready 0, `main_stall`=`main_req_valid`).

## Configuration
- `DMEM_ARB_STARVE_GUARD_EN` defined:
  - Counter (0..`STARVE_LIMIT`, reset 0) increments on each main grant while any `sub_req_valid` is high.
  - It clears on any subcore grant, or when no subcore is requesting.
  - When it equals `STARVE_LIMIT`, the round-robin subcore wins over the main core for that cycle (`main_stall`=1) and the counter clears.
- Undefined: strict main priority, no counter. Subcores may starve indefinitely.

## Structure
- Shared package: `SUBCORE_NUM`, `DATA_MEM_ADDR_W`, and the `arb_owner_t` typedef (MAIN, SUB0..) used for the response tag.
- Sub-module `rr_pick`: combinational round-robin selector (request vector, pointer → one-hot grant plus index).

## Test plan
- Only sub[2] reads addr 0x10 (mem holds 0xDEADBEEF) → `sub_req_ready[2]`=1 at T; `sub_resp_valid[2]`=1, `resp_dout`=0xDEADBEEF at T+1.
- Main and sub[0] request together, guard off → main granted, `main_stall`=0, `sub_req_ready`=0; sub[0] granted the cycle main drops.
- Subs 0..3 request continuously, no main → grants 0,1,2,3,0 on consecutive cycles; `rr_ptr` wraps 3→0.
- Guard on, `STARVE_LIMIT`=8, main and sub[1] request continuously → 8 main grants, then cycle 9 grants sub[1] with `main_stall`=1, then the pattern repeats.
- sub[0] writes 0x55 to addr 5, then main reads addr 5 next cycle → `main_resp_valid` with `resp_dout`=0x55.
- `rstn`=0 the cycle after a grant → no `resp_valid`; after release, `rr_ptr`=0 and the first subcore grant goes to sub[0] when all request.
